siete_segmentos_mux: RTL and testbench

- Time-multiplexed driver for an N-digit common-anode/cathode 7-segment display; successor to the single-digit hex decoder.
- Latches an N-nibble hex word plus decimal points and scans one digit at a time at a programmable refresh rate.
- Supports inter-digit blanking (anti-ghosting), per-digit enable, leading-zero suppression and selectable output polarity.
- Sits between the datapath (RAM/counter readout) and the board display pins.

---
 rtl/siete_segmentos_mux.sv | 136 +++++++++++++
 tb/tb_siete_segmentos_mux.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/siete_segmentos_mux.sv
// Time-multiplexed N-digit 7-segment driver: latches a hex word, scans one digit
// per refresh slot with a leading blank window, digit enables and zero suppression.
module siete_segmentos_mux #(
  parameter int N_DIGITOS       = 4,
  parameter int DIV_REFRESCO    = 50000,
  parameter int BLANCO          = 2,
  parameter bit SEG_ACTIVO_BAJO = 1'b1,
  parameter bit AN_ACTIVO_BAJO  = 1'b1,
  localparam int IW = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4*N_DIGITOS-1:0] datos,
  input  logic [N_DIGITOS-1:0]   puntos,
  input  logic [N_DIGITOS-1:0]   habilitar,
  input  logic                   supr_ceros,
  input  logic                   carga,
  output logic [6:0]             seg,
  output logic                   dp,
  output logic [N_DIGITOS-1:0]   an,
  output logic [IW-1:0]          digito_act
);

  localparam int CW = (DIV_REFRESCO > 1) ? $clog2(DIV_REFRESCO) : 1;

  function automatic logic [6:0] decode(input logic [3:0] h);
    case (h)
      4'h0: decode = 7'h3F;  4'h1: decode = 7'h06;
      4'h2: decode = 7'h5B;  4'h3: decode = 7'h4F;
      4'h4: decode = 7'h66;  4'h5: decode = 7'h6D;
      4'h6: decode = 7'h7D;  4'h7: decode = 7'h07;
      4'h8: decode = 7'h7F;  4'h9: decode = 7'h6F;
      4'hA: decode = 7'h77;  4'hB: decode = 7'h7C;
      4'hC: decode = 7'h39;  4'hD: decode = 7'h5E;
      4'hE: decode = 7'h79;  default: decode = 7'h71;
    endcase
  endfunction

  logic [4*N_DIGITOS-1:0] datos_sh_q, datos_disp_q;
  logic [N_DIGITOS-1:0]   puntos_sh_q, puntos_disp_q;
  logic [N_DIGITOS-1:0]   hab_sh_q, hab_disp_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [6:0]             seg_q, seg_d;
  logic                   dp_q, dp_d;
  logic [N_DIGITOS-1:0]   an_q, an_d;
  logic [IW-1:0]          dig_q;

  logic [3:0]           nibble;
  logic                 punto, hab, lz, dark, visible;
  logic [N_DIGITOS-1:0] an_act;
  logic [6:0]           seg_act;
  logic                 dp_act;

  // Scan position: slot counter and digit index
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (cnt_q == CW'(DIV_REFRESCO - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IW'(N_DIGITOS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  always_comb begin
    nibble = '0;
    punto  = 1'b0;
    hab    = 1'b0;
    an_act = '0;
    lz     = supr_ceros && (idx_q != '0);
    for (int i = 0; i < N_DIGITOS; i++) begin
      if (idx_q == IW'(i)) begin
        nibble    = datos_disp_q[4*i +: 4];
        punto     = puntos_disp_q[i];
        hab       = hab_disp_q[i];
        an_act[i] = 1'b1;
      end
      // Any nonzero nibble at or above the current digit breaks the leading-zero run
      if (IW'(i) >= idx_q && datos_disp_q[4*i +: 4] != 4'h0) lz = 1'b0;
    end
    dark    = !hab || lz;
    visible = (int'(cnt_q) >= BLANCO);
    an_act  = visible ? an_act : '0;
    seg_act = (visible && !dark) ? decode(nibble) : 7'h00;
    dp_act  = visible && !dark && punto;
    seg_d   = SEG_ACTIVO_BAJO ? ~seg_act : seg_act;
    dp_d    = SEG_ACTIVO_BAJO ? ~dp_act  : dp_act;
    an_d    = AN_ACTIVO_BAJO  ? ~an_act  : an_act;
  end

  // Shadow and display copies: a load reaches the outputs two edges after carga
  always_ff @(posedge clk) begin
    if (rst) begin
      datos_sh_q    <= '0;
      puntos_sh_q   <= '0;
      hab_sh_q      <= '0;
      datos_disp_q  <= '0;
      puntos_disp_q <= '0;
      hab_disp_q    <= '0;
    end else begin
      datos_disp_q  <= datos_sh_q;
      puntos_disp_q <= puntos_sh_q;
      hab_disp_q    <= hab_sh_q;
      if (carga) begin
        datos_sh_q  <= datos;
        puntos_sh_q <= puntos;
        hab_sh_q    <= habilitar;
      end
    end
  end

  // Scan state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      seg_q <= SEG_ACTIVO_BAJO ? 7'h7F : 7'h00;
      dp_q  <= SEG_ACTIVO_BAJO;
      an_q  <= AN_ACTIVO_BAJO ? '1 : '0;
      dig_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
      dig_q <= idx_q;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign digito_act = dig_q;

endmodule

// File: tb/tb_siete_segmentos_mux.sv
// Bench for siete_segmentos_mux: directed scenarios followed by random traffic,
// every cycle compared against a slot-arithmetic reference model.
module tb_siete_segmentos_mux;
  localparam int N = 4;
  localparam int DIV = 4;
  localparam int BL = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [15:0]  datos = '0;
  logic [3:0]   puntos = '0;
  logic [3:0]   habilitar = '0;
  logic         supr_ceros = 1'b0;
  logic         carga = 1'b0;
  logic [6:0]   seg;
  logic         dp;
  logic [3:0]   an;
  logic [1:0]   digito_act;

  siete_segmentos_mux #(
    .N_DIGITOS(N), .DIV_REFRESCO(DIV), .BLANCO(BL),
    .SEG_ACTIVO_BAJO(1'b1), .AN_ACTIVO_BAJO(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .datos(datos), .puntos(puntos), .habilitar(habilitar),
    .supr_ceros(supr_ceros), .carga(carga), .seg(seg), .dp(dp), .an(an),
    .digito_act(digito_act)
  );

  always #5 clk = ~clk;

  logic [6:0] dec_t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int ncomp = 0;
  int nfail = 0;

  // Reference model state: cycles since reset, loaded word, word being displayed
  int         mpos = 0;
  logic [15:0] m_sh_d = '0, m_disp_d = '0;
  logic [3:0]  m_sh_p = '0, m_disp_p = '0, m_sh_h = '0, m_disp_h = '0;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_an;
  logic [1:0]  e_dig;

  task automatic check(input string tag);
    ncomp++;
    assert (an === e_an) else begin
      nfail++; $error("FAIL %s an observed=%b expected=%b", tag, an, e_an);
    end
    ncomp++;
    assert (seg === e_seg) else begin
      nfail++; $error("FAIL %s seg observed=%b expected=%b", tag, seg, e_seg);
    end
    ncomp++;
    assert (dp === e_dp) else begin
      nfail++; $error("FAIL %s dp observed=%b expected=%b", tag, dp, e_dp);
    end
    ncomp++;
    assert (digito_act === e_dig) else begin
      nfail++; $error("FAIL %s digito_act observed=%0d expected=%0d", tag, digito_act, e_dig);
    end
  endtask

  // One clock edge: predict outputs from the model, advance it, compare #1 later
  task automatic step(input string tag);
    int cnt, idx;
    logic dark, vis;
    @(posedge clk);
    if (rst) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_dig = 2'd0;
      mpos = 0;
      m_sh_d = '0; m_sh_p = '0; m_sh_h = '0;
      m_disp_d = '0; m_disp_p = '0; m_disp_h = '0;
    end else begin
      cnt  = mpos % DIV;
      idx  = (mpos / DIV) % N;
      vis  = (cnt >= BL);
      dark = !m_disp_h[idx] ||
             (supr_ceros && idx != 0 && (m_disp_d >> (4 * idx)) == 16'h0);
      e_dig = 2'(idx);
      e_an  = vis ? ~(4'b0001 << idx) : 4'hF;
      e_seg = (vis && !dark) ? ~dec_t[(m_disp_d >> (4 * idx)) & 16'hF] : 7'h7F;
      e_dp  = (vis && !dark) ? ~m_disp_p[idx] : 1'b1;
      m_disp_d = m_sh_d; m_disp_p = m_sh_p; m_disp_h = m_sh_h;
      if (carga) begin
        m_sh_d = datos; m_sh_p = puntos; m_sh_h = habilitar;
      end
      mpos++;
    end
    #1;
    check(tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] h,
                      input string tag);
    datos = d; puntos = p; habilitar = h; carga = 1'b1;
    step(tag);
    carga = 1'b0;
  endtask

  initial begin
    // Reset and first edge after release
    rst = 1'b1;
    run(2, "reset");
    rst = 1'b0;
    step("first_after_reset");
    ncomp++;
    assert (an === 4'hF && seg === 7'h7F && dp === 1'b1 && digito_act === 2'd0) else begin
      nfail++; $error("FAIL post_reset_const observed=%b/%b/%b/%0d expected=1111/1111111/1/0",
                      an, seg, dp, digito_act);
    end

    load(16'h1234, 4'b0000, 4'b1111, "load_1234");
    run(20, "scan_1234");

    supr_ceros = 1'b1;
    load(16'h0050, 4'b0000, 4'b1111, "load_0050");
    run(18, "supr_on");
    supr_ceros = 1'b0;
    run(16, "supr_off");

    load(16'hABCD, 4'b0100, 4'b1011, "load_abcd");
    run(18, "disabled_dp");

    load(16'h1234, 4'b0000, 4'b1111, "reload");
    run(8, "prehold");
    datos = 16'hFFFF;
    run(10, "no_carga_hold");
    carga = 1'b1;
    step("carga_F_t");
    carga = 1'b0;
    run(2, "carga_F_t2");
    run(14, "show_F");

    // Reset together with carga in the middle of digit 2's slot
    for (int i = 0; i < 40 && !(((mpos / DIV) % N) == 2 && (mpos % DIV) == 2); i++)
      step("seek_d2");
    datos = 16'h5555; habilitar = 4'hF; rst = 1'b1; carga = 1'b1;
    step("rst_mid_slot");
    ncomp++;
    assert (an === 4'hF && seg === 7'h7F && dp === 1'b1 && digito_act === 2'd0) else begin
      nfail++; $error("FAIL rst_mid_const observed=%b/%b/%b/%0d expected=1111/1111111/1/0",
                      an, seg, dp, digito_act);
    end
    rst = 1'b0; carga = 1'b0;
    run(12, "after_rst");

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      datos      = 16'($urandom);
      if ($urandom_range(0, 3) == 0) datos = datos & 16'h00FF;
      if ($urandom_range(0, 5) == 0) datos = 16'h0000;
      puntos     = 4'($urandom);
      habilitar  = 4'($urandom);
      supr_ceros = 1'($urandom);
      carga      = ($urandom_range(0, 7) == 0);
      rst        = ($urandom_range(0, 99) == 0);
      step("random");
    end
    rst = 1'b0; carga = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end
endmodule
